// File: rtl/multi_pulse_generator.sv
// Multi-channel periodic pulse generator.
// Each channel counts 0..P-1 and emits a W-cycle pulse starting at every wrap.
// New period/width values land in a shadow register and are promoted to the
// active set at the next wrap (or immediately while the channel is stopped),
// so a running period is never cut short.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   en           per-channel run enable
//   sync_clr     restart all channels in phase, promoting shadow values
//   load         configuration write strobe
//   load_ch      target channel for load (out-of-range indices ignored)
//   load_period  new period in cycles (0 and 1 behave as 2)
//   load_width   new pulse width in cycles (0 disables pulses)
//   pulse        registered pulse outputs
//   wrap         registered one-cycle flag, high the cycle after a wrap
module multi_pulse_generator #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned PW_W           = 8,
  parameter int unsigned DEFAULT_PERIOD = 2500000,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_period,
  input  logic [PW_W-1:0]   load_width,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] wrap
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [PW_W-1:0]  DEF_W = PW_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] per_q, per_d;
  logic [NUM_CH-1:0][CNT_W-1:0] sh_per_q, sh_per_d;
  logic [NUM_CH-1:0][PW_W-1:0]  wid_q, wid_d;
  logic [NUM_CH-1:0][PW_W-1:0]  sh_wid_q, sh_wid_d;
  logic [NUM_CH-1:0][PW_W-1:0]  rem_q, rem_d;
  logic [NUM_CH-1:0]            pulse_q, pulse_d;
  logic [NUM_CH-1:0]            wrap_q, wrap_d;

  // Per-channel helpers
  logic [NUM_CH-1:0]            hit;
  logic [NUM_CH-1:0][CNT_W-1:0] per_eff;
  logic [NUM_CH-1:0]            at_last;

  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    wid_d    = wid_q;
    rem_d    = rem_q;
    sh_per_d = sh_per_q;
    sh_wid_d = sh_wid_q;
    wrap_d   = '0;
    pulse_d  = '0;
    hit      = '0;
    per_eff  = '0;
    at_last  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = load && (load_ch == CH_W'(i));
      // A same-cycle load is visible to any promotion happening on this edge.
      if (hit[i]) begin
        sh_per_d[i] = load_period;
        sh_wid_d[i] = load_width;
      end
      per_eff[i] = (per_q[i] < MIN_P) ? MIN_P : per_q[i];
      // >= guards against a smaller period promoted while the counter was held.
      at_last[i] = cnt_q[i] >= (per_eff[i] - CNT_W'(1));

      if (sync_clr) begin
        cnt_d[i] = '0;
        rem_d[i] = '0;
        per_d[i] = sh_per_d[i];
        wid_d[i] = sh_wid_d[i];
      end else if (!en[i]) begin
        rem_d[i] = '0;
        per_d[i] = sh_per_d[i];
        wid_d[i] = sh_wid_d[i];
      end else if (at_last[i]) begin
        // The pulse starting at a wrap belongs to the new period's config.
        cnt_d[i]  = '0;
        per_d[i]  = sh_per_d[i];
        wid_d[i]  = sh_wid_d[i];
        rem_d[i]  = sh_wid_d[i];
        wrap_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (rem_q[i] != '0) rem_d[i] = rem_q[i] - PW_W'(1);
      end
      pulse_d[i] = (rem_d[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      per_q    <= {NUM_CH{DEF_P}};
      sh_per_q <= {NUM_CH{DEF_P}};
      wid_q    <= {NUM_CH{DEF_W}};
      sh_wid_q <= {NUM_CH{DEF_W}};
      pulse_q  <= '0;
      wrap_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      per_q    <= per_d;
      sh_per_q <= sh_per_d;
      wid_q    <= wid_d;
      sh_wid_q <= sh_wid_d;
      pulse_q  <= pulse_d;
      wrap_q   <= wrap_d;
    end
  end

  assign pulse = pulse_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: directed scenarios plus random traffic,
// checked by a scoreboard against a time-since-wrap reference model.
module tb_multi_pulse_generator;

  localparam int NCH  = 2;
  localparam int NONE = 1 << 30;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync_clr = 1'b0;
  logic           load = 1'b0;
  logic [0:0]     load_ch = '0;
  logic [7:0]     load_period = '0;
  logic [3:0]     load_width = '0;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] wrap;

  multi_pulse_generator #(
    .NUM_CH(2), .CNT_W(8), .PW_W(4), .DEFAULT_PERIOD(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .load(load),
    .load_ch(load_ch), .load_period(load_period), .load_width(load_width),
    .pulse(pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];  // {pulse, wrap} expected after each edge
  string      tag_q[$];

  // Reference model: position in period, active/shadow config, time since wrap.
  int m_phase[NCH], m_p[NCH], m_w[NCH], m_sp[NCH], m_sw[NCH];
  int m_since[NCH], m_wl[NCH];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got pulse/wrap=%b required %b", name, $time, got, want);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = 0; m_p[i] = 10; m_w[i] = 1; m_sp[i] = 10; m_sw[i] = 1;
      m_since[i] = NONE; m_wl[i] = 0;
    end
  endtask

  // Apply inputs for the next edge, predict outputs after it, wait past it.
  task automatic do_cycle(input string name, input logic [1:0] e, input logic sc,
                          input logic ld, input int ch, input int p, input int w);
    logic [1:0] ep, ew;
    int pe;
    en = e; sync_clr = sc; load = ld; load_ch = 1'(ch);
    load_period = 8'(p); load_width = 4'(w);
    for (int i = 0; i < NCH; i++) begin
      if (ld && ch == i) begin m_sp[i] = p; m_sw[i] = w; end
      ew[i] = 1'b0;
      if (sc) begin
        m_phase[i] = 0; m_since[i] = NONE; m_p[i] = m_sp[i]; m_w[i] = m_sw[i];
      end else if (!e[i]) begin
        m_since[i] = NONE; m_p[i] = m_sp[i]; m_w[i] = m_sw[i];
      end else begin
        pe = (m_p[i] < 2) ? 2 : m_p[i];
        if (m_phase[i] + 1 >= pe) begin
          m_phase[i] = 0; m_p[i] = m_sp[i]; m_w[i] = m_sw[i];
          m_since[i] = 0; m_wl[i] = m_w[i]; ew[i] = 1'b1;
        end else begin
          m_phase[i]++;
          if (m_since[i] != NONE) m_since[i]++;
        end
      end
      ep[i] = (m_since[i] != NONE) && (m_since[i] < m_wl[i]);
    end
    exp_q.push_back({ep, ew});
    tag_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input string name, input int n, input logic [1:0] e);
    for (int k = 0; k < n; k++) do_cycle(name, e, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Called between edges with the scoreboard drained.
  task automatic apply_reset(input string name);
    rst = 1'b1; en = '0; sync_clr = 1'b0; load = 1'b0;
    #1 check({name, "_async"}, {pulse, wrap}, 4'b0000);
    @(posedge clk); @(posedge clk); #1;
    check({name, "_held"}, {pulse, wrap}, 4'b0000);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT outputs against queued expectations after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(tag_q.pop_front(), {pulse, wrap}, exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #2;
    apply_reset("reset");

    // Default period 10, width 1 on both channels.
    run("default", 25, 2'b11);

    // Reconfigure ch0 mid-period; takes effect at the wrap on edge 10.
    apply_reset("reset2");
    run("pre_load", 2, 2'b11);
    do_cycle("load_ch0", 2'b11, 1'b0, 1'b1, 0, 4, 2);
    run("after_load", 30, 2'b11);

    // Edge cases: P=1, W=0, then W>P.
    do_cycle("load_p1", 2'b11, 1'b0, 1'b1, 0, 1, 1);
    do_cycle("load_w0", 2'b11, 1'b0, 1'b1, 1, 4, 0);
    run("edge_a", 24, 2'b11);
    do_cycle("load_wide", 2'b11, 1'b0, 1'b1, 0, 4, 5);
    run("edge_b", 20, 2'b11);

    // Disable ch0 while counting, then resume from held count.
    apply_reset("reset3");
    run("pre_dis", 6, 2'b11);
    run("disabled", 5, 2'b10);
    run("resumed", 16, 2'b11);

    // sync_clr together with a load to ch1.
    apply_reset("reset4");
    run("pre_sync", 6, 2'b11);
    do_cycle("sync_load", 2'b11, 1'b1, 1'b1, 1, 6, 1);
    run("post_sync", 22, 2'b11);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic [1:0] e;
      logic sc, ld;
      e  = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom);
      sc = ($urandom_range(0, 49) == 0);
      ld = ($urandom_range(0, 9) == 0);
      do_cycle("random", e, sc, ld, $urandom_range(0, 1), $urandom_range(0, 12),
               $urandom_range(0, 6));
    end

    // Reset during a pulse, then the default timing again.
    apply_reset("reset5");
    run("to_pulse", 10, 2'b11);
    apply_reset("reset_mid_pulse");
    run("after_rst", 22, 2'b11);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
